fifo_sample_reader: RTL and testbench
=====================================

// Module: fifo_sample_reader
// PURPOSE
//  Read-side controller for the sensor input buffer FIFO. Pops bytes from the FIFO
//  and packs NUM_FEATURES consecutive bytes into one feature-vector sample. Presents
//  each sample to the isolation-tree scorer over a valid/ready handshake.
//  Sits between the input buffer FIFO and the anomaly-scoring pipeline.
// PARAMETERS
//  NUM_FEATURES   4    bytes per sample; range 2..16
//  TIMEOUT_CYCLES 256  partial-sample stall limit; used only with READER_TIMEOUT_EN
// PORTS
//  clk            in   1                 single clock, rising edge
//  reset          in   1                 asynchronous, active-low; 0 = in reset
//  fifo_output    in   8                 FIFO read data; valid 1 cycle after a pop
//  fifo_empty     in   1                 FIFO empty flag
//  read_enable    out  1                 FIFO pop strobe
//  sample_data    out  8*NUM_FEATURES    packed sample; byte 0 = first byte popped
//  sample_valid   out  1                 sample_data is valid
//  sample_ready   in   1                 scorer accepts sample
//  sample_dropped out  1                 1-cycle pulse: partial sample discarded (timeout)
// BEHAVIOUR
//  Reset values: read_enable=0, sample_valid=0, sample_data=0, sample_dropped=0,
//   byte index=0, state=S_FETCH.
//  Reset asserted mid-sample discards all partial bytes.
//  States:
//   S_FETCH   - read_enable = !fifo_empty (combinational).
//               If !fifo_empty: go to S_CAPTURE. Else stay.
//   S_CAPTURE - write fifo_output into byte slot idx.
//               If idx==NUM_FEATURES-1: idx<=0, go to S_PRESENT.
//               Else: idx<=idx+1, go to S_FETCH.
//   S_PRESENT - sample_valid=1; sample_data held stable.
//               If sample_ready: go to S_FETCH, next cycle sample_valid=0.
//               read_enable=0 throughout.
//  Throughput: 2 cycles per byte. Minimum latency from first pop to sample_valid
//   is 2*NUM_FEATURES cycles.
//  Backpressure: while in S_PRESENT no pops occur, so the FIFO absorbs the stall.
//  Never pops while fifo_empty=1, so the FIFO cannot underflow.
//  sample_valid must not drop before the handshake. Data must not change while
//   valid=1 and ready=0.
//  Byte index width: $clog2(NUM_FEATURES).
//  Slots not yet written in the current sample keep the previous sample's values.
// CONFIGURATION
//  READER_TIMEOUT_EN defined:
//   - A counter runs while idx!=0 in S_FETCH with fifo_empty=1.
//   - On reaching TIMEOUT_CYCLES: idx<=0, pulse sample_dropped for 1 cycle, stay in S_FETCH.
//   - The counter clears on any pop.
//  READER_TIMEOUT_EN undefined:
//   - Partial samples wait indefinitely.
//   - sample_dropped is tied to 0.
// STRUCTURE
//  Shared package iforest_pkg holds:
//   - state encodings S_FETCH=2'd0, S_CAPTURE=2'd1, S_PRESENT=2'd2
//   - SENSOR_BYTE_W=8
//   - default NUM_FEATURES
//  Optional sub-module sample_timeout_ctr, present only under READER_TIMEOUT_EN.
//   Ports: clk, reset, run, clear, expired.
// TESTING
//  Use NUM_FEATURES=4 with a behavioural FIFO model.
//  1. Reset release with empty FIFO, 20 cycles -> read_enable=0 and sample_valid=0 throughout.
//  2. Push 11,22,33,44, ready held 1 -> sample_data=32'h44332211 after 8 cycles;
//     valid high exactly 1 cycle; exactly 4 pops.
//  3. Push 8 bytes, ready held 0 for 10 cycles -> first sample stable with valid=1;
//     no pops; FIFO count=4. Raise ready -> second sample follows.
//  4. FIFO empties after 2 bytes -> no read_enable while empty. Push 2 more -> sample completes.
//  5. Assert reset after 3 bytes popped -> all outputs return to 0.
//     The next 4 bytes form a fresh sample with no stale bytes in low slots.
//  6. With READER_TIMEOUT_EN, TIMEOUT_CYCLES=16, stall after 1 byte ->
//     sample_dropped pulses at cycle 16. The next 4 bytes form a clean sample.

Source files
------------

// File: rtl/iforest_pkg.sv
// Shared definitions for the isolation-forest front end: reader state encoding,
// sensor byte width and the default feature count.
package iforest_pkg;

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_CAPTURE = 2'd1,
    S_PRESENT = 2'd2
  } reader_state_t;

  localparam int unsigned SENSOR_BYTE_W        = 8;
  localparam int unsigned DEFAULT_NUM_FEATURES = 4;

  // Index width that never collapses to zero bits.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sample_timeout_ctr.sv
// Stall counter for partially assembled samples; expired is a combinational strobe
// on the TIMEOUT_CYCLES-th consecutive cycle with run high.
module sample_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] count;

  assign expired = run && (count == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear || expired) begin
      count <= '0;
    end else if (run) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_sample_reader.sv
// Pops sensor bytes from the input FIFO and packs NUM_FEATURES of them into one sample
// for the scorer. Optional partial-sample timeout is built when READER_TIMEOUT_EN is defined.
module fifo_sample_reader
  import iforest_pkg::*;
#(
  parameter int unsigned NUM_FEATURES   = DEFAULT_NUM_FEATURES,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [SENSOR_BYTE_W-1:0]              fifo_output,
  input  logic                                  fifo_empty,
  output logic                                  read_enable,
  output logic [SENSOR_BYTE_W*NUM_FEATURES-1:0] sample_data,
  output logic                                  sample_valid,
  input  logic                                  sample_ready,
  output logic                                  sample_dropped
);

  localparam int unsigned IDX_W = idx_width(NUM_FEATURES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEATURES - 1);

  reader_state_t    state;
  logic [IDX_W-1:0] idx;
  logic             timeout_expired;

  // Gated by reset so no pop strobe escapes while the block is held in reset.
  assign read_enable = reset && (state == S_FETCH) && !fifo_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_FETCH;
      idx          <= '0;
      sample_data  <= '0;
      sample_valid <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (!fifo_empty) begin
            state <= S_CAPTURE;
          end else if (timeout_expired) begin
            idx <= '0;
          end
        end
        S_CAPTURE: begin
          for (int unsigned i = 0; i < NUM_FEATURES; i++) begin
            if (idx == IDX_W'(i)) begin
              sample_data[i*SENSOR_BYTE_W +: SENSOR_BYTE_W] <= fifo_output;
            end
          end
          if (idx == LAST_IDX) begin
            idx          <= '0;
            state        <= S_PRESENT;
            sample_valid <= 1'b1;
          end else begin
            idx   <= idx + 1'b1;
            state <= S_FETCH;
          end
        end
        S_PRESENT: begin
          if (sample_ready) begin
            state        <= S_FETCH;
            sample_valid <= 1'b0;
          end
        end
        default: begin
          state        <= S_FETCH;
          sample_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef READER_TIMEOUT_EN
  logic stall_run;

  // Only a partially filled sample waiting on an empty FIFO counts as a stall.
  assign stall_run = (state == S_FETCH) && fifo_empty && (idx != '0);

  sample_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk    (clk),
    .reset  (reset),
    .run    (stall_run),
    .clear  (read_enable),
    .expired(timeout_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample_dropped <= 1'b0;
    end else begin
      sample_dropped <= (state == S_FETCH) && timeout_expired;
    end
  end
`else
  assign timeout_expired = 1'b0;
  assign sample_dropped  = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_sample_reader.sv
// Directed bench for fifo_sample_reader (NUM_FEATURES=4) with a behavioural FIFO and a
// sample scoreboard; the stall scenario follows READER_TIMEOUT_EN.
module tb_fifo_sample_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  fifo_output = 8'h00;
  logic        fifo_empty;
  logic        read_enable;
  logic [31:0] sample_data;
  logic        sample_valid;
  logic        sample_ready = 1'b0;
  logic        sample_dropped;

  int checks = 0;
  int errors = 0;
  int pushed = 0;
  int pops = 0;
  int accepted = 0;

  logic [7:0]  fifo_q[$];
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  fifo_sample_reader #(
    .NUM_FEATURES  (4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .fifo_output   (fifo_output),
    .fifo_empty    (fifo_empty),
    .read_enable   (read_enable),
    .sample_data   (sample_data),
    .sample_valid  (sample_valid),
    .sample_ready  (sample_ready),
    .sample_dropped(sample_dropped)
  );

  assign fifo_empty = (pushed == pops);

  // Read data appears one cycle after the pop strobe.
  always @(posedge clk) begin
    if (read_enable && fifo_q.size() != 0) begin
      fifo_output <= fifo_q.pop_front();
      pops        <= pops + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    pushed++;
  endtask

  task automatic push_sample(input logic [31:0] s);
    for (int i = 0; i < 4; i++) push(s[i*8 +: 8]);
    exp_q.push_back(s);
  endtask

  // Checks handshake and underflow as seen by the coming edge, then advances one cycle.
  task automatic tick();
    if (sample_valid && sample_ready) begin
      accepted++;
      if (exp_q.size() == 0) check("unexpected_sample", sample_data, 64'hdead);
      else check("sample_data", sample_data, exp_q.pop_front());
    end
    if (read_enable) check("no_pop_when_empty", fifo_empty, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (!sample_valid && n < budget) begin
      tick();
      n++;
    end
    check(tag, sample_valid, 1);
  endtask

  initial begin
    int p0;
    int a0;
    int n;

    // Reset state
    repeat (3) tick();
    check("rst_read_enable", read_enable, 0);
    check("rst_valid", sample_valid, 0);
    check("rst_data", sample_data, 0);
    check("rst_dropped", sample_dropped, 0);

    // 1: idle with empty FIFO
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_read_enable", read_enable, 0);
      check("idle_valid", sample_valid, 0);
    end

    // 2: single sample, ready held high
    sample_ready = 1'b1;
    p0 = pops;
    push_sample(32'h44332211);
    repeat (7) tick();
    check("lat_valid_low", sample_valid, 0);
    tick();
    check("lat_valid_high", sample_valid, 1);
    check("lat_data", sample_data, 32'h44332211);
    tick();
    check("valid_one_cycle", sample_valid, 0);
    check("pops_4", pops - p0, 4);

    // 3: backpressure
    sample_ready = 1'b0;
    p0 = pops;
    a0 = accepted;
    push_sample(32'h8877_6655);
    push_sample(32'hccbb_aa99);
    wait_valid("bp_first_valid", 30);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_valid_held", sample_valid, 1);
      check("bp_data_stable", sample_data, 32'h8877_6655);
    end
    check("bp_pops", pops - p0, 4);
    check("bp_fifo_count", pushed - pops, 4);
    sample_ready = 1'b1;
    n = 0;
    while (accepted - a0 < 2 && n < 40) begin
      tick();
      n++;
    end
    check("bp_accepted", accepted - a0, 2);

    // 4: FIFO runs dry mid-sample
    p0 = pops;
    push(8'h01);
    push(8'h02);
    repeat (12) tick();
    check("dry_valid", sample_valid, 0);
    check("dry_pops", pops - p0, 2);
    push(8'h03);
    push(8'h04);
    exp_q.push_back(32'h0403_0201);
    wait_valid("dry_complete", 20);
    tick();
    check("dry_sb_empty", exp_q.size(), 0);

    // 5: reset mid-sample
    push(8'he1);
    push(8'he2);
    push(8'he3);
    repeat (7) tick();
    reset = 1'b0;
    tick();
    check("mid_rst_read_enable", read_enable, 0);
    check("mid_rst_valid", sample_valid, 0);
    check("mid_rst_data", sample_data, 0);
    check("mid_rst_dropped", sample_dropped, 0);
    reset = 1'b1;
    tick();
    push_sample(32'ha4a3_a2a1);
    wait_valid("post_rst_valid", 20);
    check("post_rst_data", sample_data, 32'ha4a3_a2a1);
    tick();

    // 6: stalled partial sample
`ifdef READER_TIMEOUT_EN
    push(8'h5a);
    n = 0;
    while (!sample_dropped && n < 40) begin
      tick();
      n++;
    end
    check("drop_cycle", n, 18);
    tick();
    check("drop_one_cycle", sample_dropped, 0);
    check("drop_no_valid", sample_valid, 0);
    push_sample(32'h7473_7271);
    wait_valid("drop_clean_valid", 20);
    check("drop_clean_data", sample_data, 32'h7473_7271);
    tick();
`else
    push(8'h71);
    for (int i = 0; i < 40; i++) begin
      tick();
      check("stall_no_drop", sample_dropped, 0);
    end
    check("stall_no_valid", sample_valid, 0);
    push(8'h72);
    push(8'h73);
    push(8'h74);
    exp_q.push_back(32'h7473_7271);
    wait_valid("stall_complete", 20);
    tick();
`endif
    check("final_sb_empty", exp_q.size(), 0);
    check("final_fifo_empty", fifo_empty, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
